// File: rtl/offchip_mem_arbiter_if.sv
// offchip_mem_arbiter_if: every signal of the off-chip arbiter in one bundle.
// It covers the two cache-side request channels (i_*, d_*) and the downstream
// off-chip channel (mem_*).
// master: the arbiter's view (it masters the off-chip channel).
// slave : the surrounding caches and off-chip memory.
interface offchip_mem_arbiter_if #(
    parameter int LINE_BITS = 256
);
    logic                 i_read_en, i_write_en;
    logic [31:0]          i_addr;
    logic [LINE_BITS-1:0] i_wdata, i_rdata;
    logic                 i_ready, i_read_busy, i_write_busy;

    logic                 d_read_en, d_write_en;
    logic [31:0]          d_addr;
    logic [LINE_BITS-1:0] d_wdata, d_rdata;
    logic                 d_ready, d_read_busy, d_write_busy;

    logic                 mem_read_en, mem_write_en;
    logic [31:0]          mem_addr;
    logic [LINE_BITS-1:0] mem_wdata, mem_rdata;
    logic                 mem_ready, mem_timeout;

    modport master (
        input  i_read_en, i_write_en, i_addr, i_wdata,
        output i_rdata, i_ready, i_read_busy, i_write_busy,
        input  d_read_en, d_write_en, d_addr, d_wdata,
        output d_rdata, d_ready, d_read_busy, d_write_busy,
        output mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_timeout,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_read_en, i_write_en, i_addr, i_wdata,
        input  i_rdata, i_ready, i_read_busy, i_write_busy,
        output d_read_en, d_write_en, d_addr, d_wdata,
        input  d_rdata, d_ready, d_read_busy, d_write_busy,
        input  mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_timeout,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/offchip_mem_arbiter.sv
// offchip_mem_arbiter: shares the off-chip line-transfer channel between the
// I-cache (port I) and D-cache (port D). One transaction at a time, round-robin
// between ports on a tie, grant held until the memory answers.
// Optional watchdog: define OFFCHIP_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES silent WAIT cycles.
module offchip_mem_arbiter #(
    parameter int LINE_BITS      = 256,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    offchip_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t               state;
    logic                 owner;      // port holding the grant
    logic                 op_wr;      // granted op is a write
    logic                 rr_ptr;     // preferred port when both request
    logic                 mem_read_en_q, mem_write_en_q;
    logic [31:0]          mem_addr_q;
    logic [LINE_BITS-1:0] mem_wdata_q;
    logic [LINE_BITS-1:0] i_rdata_q, d_rdata_q;
    logic                 i_ready_q, d_ready_q;

    logic i_req, d_req, gnt_d, gnt_wr, done;
    logic [LINE_BITS-1:0] resp_data;

    assign i_req  = bus.i_read_en | bus.i_write_en;
    assign d_req  = bus.d_read_en | bus.d_write_en;
    // D wins when it is the only requester or when the pointer names it.
    assign gnt_d  = d_req & (~i_req | (rr_ptr == PORT_D));
    // Write beats read inside a port; the read is served in a later transaction.
    assign gnt_wr = gnt_d ? bus.d_write_en : bus.i_write_en;

`ifdef OFFCHIP_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
    logic             expired;
    // Terminal count reached on this WAIT cycle; a coincident mem_ready wins.
    assign expired   = (wait_cnt == CNT_LAST) & ~bus.mem_ready;
    assign resp_data = bus.mem_ready ? bus.mem_rdata : '0;
    assign bus.mem_timeout = timeout_q;
`else
    logic expired;
    assign expired   = 1'b0;
    assign resp_data = bus.mem_rdata;
    assign bus.mem_timeout = 1'b0;
`endif

    assign done = bus.mem_ready | expired;

    // Arbitration FSM; all outputs registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            owner          <= PORT_I;
            op_wr          <= 1'b0;
            rr_ptr         <= PORT_I;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_ready_q      <= 1'b0;
            d_ready_q      <= 1'b0;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        owner          <= gnt_d;
                        op_wr          <= gnt_wr;
                        mem_read_en_q  <= ~gnt_wr;
                        mem_write_en_q <= gnt_wr;
                        mem_addr_q     <= gnt_d ? bus.d_addr : bus.i_addr;
                        mem_wdata_q    <= gnt_d ? bus.d_wdata : bus.i_wdata;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
                        wait_cnt       <= '0;
`endif
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        mem_read_en_q  <= 1'b0;
                        mem_write_en_q <= 1'b0;
                        if (!op_wr) begin
                            if (owner == PORT_D) d_rdata_q <= resp_data;
                            else                 i_rdata_q <= resp_data;
                        end
                        if (owner == PORT_D) d_ready_q <= 1'b1;
                        else                 i_ready_q <= 1'b1;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
                        timeout_q      <= expired;
`endif
                        state          <= RESP;
                    end
`ifdef OFFCHIP_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                    rr_ptr    <= ~owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read_en  = mem_read_en_q;
    assign bus.mem_write_en = mem_write_en_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.i_ready      = i_ready_q;
    assign bus.d_ready      = d_ready_q;

    assign bus.i_read_busy  = (state != IDLE) & (owner == PORT_I) & ~op_wr;
    assign bus.i_write_busy = (state != IDLE) & (owner == PORT_I) &  op_wr;
    assign bus.d_read_busy  = (state != IDLE) & (owner == PORT_D) & ~op_wr;
    assign bus.d_write_busy = (state != IDLE) & (owner == PORT_D) &  op_wr;
endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// tb_offchip_mem_arbiter: vector table, hand sequences (timeout/no-timeout,
// async reset), then randomized traffic against a transaction-level model.
module tb_offchip_mem_arbiter;
    localparam int LB = 64;
    localparam int TO = 8;
    localparam logic [31:0] I_ADDR = 32'h100;
    localparam logic [31:0] D_ADDR = 32'h200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    offchip_mem_arbiter_if #(.LINE_BITS(LB)) bus ();
    offchip_mem_arbiter #(.LINE_BITS(LB), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {mre, mwe, i_ready, d_ready, i_rbusy, i_wbusy, d_rbusy, d_wbusy}
    function automatic logic [7:0] flags();
        return {bus.mem_read_en, bus.mem_write_en, bus.i_ready, bus.d_ready,
                bus.i_read_busy, bus.i_write_busy, bus.d_read_busy, bus.d_write_busy};
    endfunction

    function automatic logic [3:0] exp_busy(input bit port, input bit wr);
        if (!port) return wr ? 4'b0100 : 4'b1000;
        return wr ? 4'b0001 : 4'b0010;
    endfunction

    task automatic idle_inputs();
        bus.i_read_en = 0; bus.i_write_en = 0; bus.i_addr = I_ADDR; bus.i_wdata = {8{8'h11}};
        bus.d_read_en = 0; bus.d_write_en = 0; bus.d_addr = D_ADDR; bus.d_wdata = {8{8'h22}};
        bus.mem_ready = 0; bus.mem_rdata = '0;
    endtask

    // One complete transaction with the memory answering in its first cycle.
    task automatic xfer(input bit port, input bit wr, input logic [LB-1:0] dat);
        bit seen;
        seen = 0;
        if (port) begin bus.d_read_en = !wr; bus.d_write_en = wr; end
        else      begin bus.i_read_en = !wr; bus.i_write_en = wr; end
        for (int t = 0; t < 8 && !seen; t++) begin
            @(negedge clk);
            seen = bus.mem_read_en | bus.mem_write_en;
        end
        check("xfer_grant", LB'(seen), 1);
        bus.mem_ready = 1; bus.mem_rdata = dat;
        @(negedge clk);
        bus.mem_ready = 0;
        check("xfer_ready", LB'(port ? bus.d_ready : bus.i_ready), 1);
        bus.i_read_en = 0; bus.i_write_en = 0; bus.d_read_en = 0; bus.d_write_en = 0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] req;    // {i_rd, i_wr, d_rd, d_wr}
        logic       mrdy;
        logic [7:0] mbyte;
        logic [7:0] exp;    // flags() after the edge
        logic [7:0] ei, ed; // expected i_rdata / d_rdata byte pattern
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, input logic mrdy, input logic [7:0] mb,
                                input logic [7:0] exp, input logic [7:0] ei, input logic [7:0] ed);
        vec_t v;
        v.req = req; v.mrdy = mrdy; v.mbyte = mb; v.exp = exp; v.ei = ei; v.ed = ed;
        return v;
    endfunction

    vec_t vt[28];

    // random-phase model state
    bit              pend[2], prd[2], pwr[2];
    logic [31:0]     paddr[2];
    logic [LB-1:0]   pwd[2];
    logic [LB-1:0]   exp_rd[2];
    logic [LB-1:0]   sent;
    bit              act, own, owr, resp_due, in_txn;
    int              lat, since_rdy, last_own, w;
    logic [1:0]      rdy, en;
    logic [3:0]      busy;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // both-request tie from reset, continuous re-request: I, D, I, D
        vt[0]  = mk(4'b1010, 0, 8'h00, 8'b1000_1000, 8'h00, 8'h00);
        vt[1]  = mk(4'b1010, 1, 8'hD1, 8'b0010_1000, 8'hD1, 8'h00);
        vt[2]  = mk(4'b1010, 0, 8'h00, 8'b0000_0000, 8'hD1, 8'h00);
        vt[3]  = mk(4'b1010, 0, 8'h00, 8'b1000_0010, 8'hD1, 8'h00);
        vt[4]  = mk(4'b1010, 1, 8'hD2, 8'b0001_0010, 8'hD1, 8'hD2);
        vt[5]  = mk(4'b1010, 0, 8'h00, 8'b0000_0000, 8'hD1, 8'hD2);
        vt[6]  = mk(4'b1010, 0, 8'h00, 8'b1000_1000, 8'hD1, 8'hD2);
        vt[7]  = mk(4'b1010, 1, 8'hD3, 8'b0010_1000, 8'hD3, 8'hD2);
        vt[8]  = mk(4'b1010, 0, 8'h00, 8'b0000_0000, 8'hD3, 8'hD2);
        vt[9]  = mk(4'b1010, 0, 8'h00, 8'b1000_0010, 8'hD3, 8'hD2);
        vt[10] = mk(4'b1010, 1, 8'hD4, 8'b0001_0010, 8'hD3, 8'hD4);
        vt[11] = mk(4'b0000, 0, 8'h00, 8'b0000_0000, 8'hD3, 8'hD4);
        // D read+write together: write first, rdata untouched, then read
        vt[12] = mk(4'b0011, 0, 8'h00, 8'b0100_0001, 8'hD3, 8'hD4);
        vt[13] = mk(4'b0011, 1, 8'hEE, 8'b0001_0001, 8'hD3, 8'hD4);
        vt[14] = mk(4'b0010, 0, 8'h00, 8'b0000_0000, 8'hD3, 8'hD4);
        vt[15] = mk(4'b0010, 0, 8'h00, 8'b1000_0010, 8'hD3, 8'hD4);
        vt[16] = mk(4'b0010, 1, 8'hD5, 8'b0001_0010, 8'hD3, 8'hD5);
        vt[17] = mk(4'b0000, 0, 8'h00, 8'b0000_0000, 8'hD3, 8'hD5);
        // I read, memory answers after 3 cycles
        vt[18] = mk(4'b1000, 0, 8'h00, 8'b1000_1000, 8'hD3, 8'hD5);
        vt[19] = mk(4'b1000, 0, 8'h00, 8'b1000_1000, 8'hD3, 8'hD5);
        vt[20] = mk(4'b1000, 0, 8'h00, 8'b1000_1000, 8'hD3, 8'hD5);
        vt[21] = mk(4'b1000, 1, 8'hA5, 8'b0010_1000, 8'hA5, 8'hD5);
        vt[22] = mk(4'b0000, 0, 8'h00, 8'b0000_0000, 8'hA5, 8'hD5);
        // stray mem_ready in IDLE
        vt[23] = mk(4'b0000, 1, 8'hFF, 8'b0000_0000, 8'hA5, 8'hD5);
        vt[24] = mk(4'b0000, 0, 8'h00, 8'b0000_0000, 8'hA5, 8'hD5);
        // I write leaves i_rdata alone
        vt[25] = mk(4'b0100, 0, 8'h00, 8'b0100_0100, 8'hA5, 8'hD5);
        vt[26] = mk(4'b0100, 1, 8'h77, 8'b0010_0100, 8'hA5, 8'hD5);
        vt[27] = mk(4'b0000, 0, 8'h00, 8'b0000_0000, 8'hA5, 8'hD5);

        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset_flags", LB'(flags()), 0);
        check("reset_i_rdata", bus.i_rdata, 0);
        check("reset_d_rdata", bus.d_rdata, 0);
        check("reset_mem_addr", LB'(bus.mem_addr), 0);
        check("reset_mem_wdata", bus.mem_wdata, 0);
        check("reset_timeout", LB'(bus.mem_timeout), 0);
        rst = 1;

        for (int k = 0; k < 28; k++) begin
            {bus.i_read_en, bus.i_write_en, bus.d_read_en, bus.d_write_en} = vt[k].req;
            bus.mem_ready = vt[k].mrdy;
            bus.mem_rdata = {8{vt[k].mbyte}};
            @(negedge clk);
            check($sformatf("vec%0d_flags", k), LB'(flags()), LB'(vt[k].exp));
            check($sformatf("vec%0d_i_rdata", k), bus.i_rdata, {8{vt[k].ei}});
            check($sformatf("vec%0d_d_rdata", k), bus.d_rdata, {8{vt[k].ed}});
            if (vt[k].exp[7] | vt[k].exp[6])
                check($sformatf("vec%0d_addr", k), LB'(bus.mem_addr),
                      LB'((vt[k].exp[3] | vt[k].exp[2]) ? I_ADDR : D_ADDR));
            if (vt[k].exp[6])
                check($sformatf("vec%0d_wdata", k), bus.mem_wdata,
                      vt[k].exp[2] ? {8{8'h11}} : {8{8'h22}});
        end
        idle_inputs();

`ifdef OFFCHIP_ARB_TIMEOUT_EN
        bus.i_read_en = 1;
        repeat (TO) @(negedge clk);
        check("to_still_wait", LB'({bus.mem_read_en, bus.mem_timeout, bus.i_ready}), 3'b100);
        @(negedge clk);
        check("to_pulse", LB'({bus.mem_read_en, bus.mem_timeout, bus.i_ready}), 3'b011);
        check("to_rdata_zero", bus.i_rdata, 0);
        bus.i_read_en = 0;
        @(negedge clk);
        check("to_pulse_end", LB'({bus.mem_timeout, bus.i_ready}), 0);
        xfer(0, 0, {8{8'h5A}});
        check("to_next_ok", bus.i_rdata, {8{8'h5A}});
`else
        bus.i_read_en = 1;
        repeat (20) @(negedge clk);
        check("nto_still_wait", LB'({bus.mem_read_en, bus.mem_timeout, bus.i_ready}), 3'b100);
        bus.mem_ready = 1; bus.mem_rdata = {8{8'h5A}};
        @(negedge clk);
        bus.mem_ready = 0;
        check("nto_ready", LB'({bus.mem_read_en, bus.mem_timeout, bus.i_ready}), 3'b001);
        check("nto_rdata", bus.i_rdata, {8{8'h5A}});
        bus.i_read_en = 0;
        @(negedge clk);
`endif

        // async reset while D owns the channel; pointer must return to I
        xfer(0, 0, {8{8'h3C}});
        check("rst_pre_i_rdata", bus.i_rdata, {8{8'h3C}});
        bus.d_read_en = 1;
        @(negedge clk);
        check("rst_pre_wait", LB'(flags()), 8'b1000_0010);
        @(posedge clk);
        #2 rst = 0;
        #1;
        check("rst_async_en", LB'({bus.mem_read_en, bus.mem_write_en}), 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        bus.d_read_en = 0;
        @(negedge clk);
        check("rst_no_ready", LB'(flags()), 0);
        rst = 1;
        bus.i_read_en = 1; bus.d_read_en = 1;
        @(negedge clk);
        check("rst_ptr_i", LB'(flags()), 8'b1000_1000);

        // clean restart for the randomized phase
        rst = 0;
        idle_inputs();
        @(negedge clk);
        rst = 1;

        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; prd[p] = 0; pwr[p] = 0; paddr[p] = '0; pwd[p] = '0; exp_rd[p] = '0;
        end
        act = 0; own = 0; owr = 0; resp_due = 0; lat = 0; since_rdy = 10; last_own = 1; sent = '0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rdy  = {bus.d_ready, bus.i_ready};
            en   = {bus.mem_read_en, bus.mem_write_en};
            busy = {bus.i_read_busy, bus.i_write_busy, bus.d_read_busy, bus.d_write_busy};
            in_txn = 0;
            check("r_timeout", LB'(bus.mem_timeout), 0);
            if (resp_due) begin
                resp_due = 0; act = 0; in_txn = 1;
                check("r_ready", LB'(rdy), own ? 2'b10 : 2'b01);
                check("r_en_drop", LB'(en), 0);
                if (!owr) exp_rd[own] = sent;
                if (owr && prd[own]) pwr[own] = 0;
                else pend[own] = 0;
                last_own = int'(own);
                since_rdy = 0;
            end else begin
                check("r_no_ready", LB'(rdy), 0);
                since_rdy++;
                if (!act && en != 2'b00) begin
                    if (pend[0] && pend[1]) w = 1 - last_own;
                    else if (pend[1])       w = 1;
                    else                    w = 0;
                    check("r_grant_had_req", LB'(pend[0] | pend[1]), 1);
                    check("r_grant_gap", LB'(since_rdy >= 2), 1);
                    act = 1; own = w[0]; owr = pwr[own];
                    lat = $urandom_range(0, 3);
                end
                if (act) begin
                    in_txn = 1;
                    check("r_en_op", LB'(en), owr ? 2'b01 : 2'b10);
                    check("r_addr", LB'(bus.mem_addr), LB'(paddr[own]));
                    if (owr) check("r_wdata", bus.mem_wdata, pwd[own]);
                end else begin
                    check("r_grant_due", LB'((pend[0] | pend[1]) && since_rdy >= 2), 0);
                end
            end
            check("r_busy", LB'(busy), in_txn ? LB'(exp_busy(own, owr)) : 0);
            check("r_i_rdata", bus.i_rdata, exp_rd[0]);
            check("r_d_rdata", bus.d_rdata, exp_rd[1]);

            bus.mem_ready = 0;
            if (act) begin
                if (lat == 0) begin
                    sent = {$urandom, $urandom};
                    bus.mem_rdata = sent;
                    bus.mem_ready = 1;
                    resp_due = 1;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.mem_ready = 1;
                bus.mem_rdata = {$urandom, $urandom};
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    int k;
                    k = $urandom_range(0, 2);
                    pend[p] = 1; prd[p] = (k != 1); pwr[p] = (k != 0);
                    paddr[p] = $urandom; pwd[p] = {$urandom, $urandom};
                end
            end
            bus.i_read_en = pend[0] & prd[0]; bus.i_write_en = pend[0] & pwr[0];
            bus.i_addr = paddr[0]; bus.i_wdata = pwd[0];
            bus.d_read_en = pend[1] & prd[1]; bus.d_write_en = pend[1] & pwr[1];
            bus.d_addr = paddr[1]; bus.d_wdata = pwd[1];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/offchip_mem_arbiter.md
# offchip_mem_arbiter

Shares the single off-chip memory line-transfer channel between the instruction cache (port I) and the data cache (port D), which would otherwise drive the same channel directly. Each cache sees a private request/ready channel of the same shape as the off-chip port. The arbiter serialises transactions with round-robin grant and holds the grant for the whole transaction. It sits inside `sys_bus`, between the two `mem_controller` instances and the off-chip memory interface.

## Interface
- `LINE_BITS`, default 256 — cache line width in bits (`CACHE_LINE_SIZE`*8).
- `TIMEOUT_CYCLES`, default 1023 — watchdog limit; used only with `OFFCHIP_ARB_TIMEOUT_EN`.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1 — clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `i_read_en`, `i_write_en` in 1 each — port I request, level.
- `i_addr` in 32 — port I line address.
- `i_wdata` in LINE_BITS — port I write line.
- `i_rdata` out LINE_BITS — port I read line.
- `i_ready` out 1 — port I completion pulse.
- `i_read_busy`, `i_write_busy` out 1 each — port I transaction in flight.
- `d_*` — the same set of ports as `i_*`, for port D.
- `mem_read_en`, `mem_write_en` out 1 each — downstream request, registered.
- `mem_addr` out 32 — downstream address.
- `mem_wdata` out LINE_BITS — downstream write line.
- `mem_rdata` in LINE_BITS — downstream read line, valid with `mem_ready`.
- `mem_ready` in 1 — downstream completion, one-cycle pulse.
- `mem_timeout` out 1 — timeout error pulse.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - Samples requests.
  - A port requests if `read_en` or `write_en` is high.
  - If both ports request, grant goes to the port named by the round-robin pointer.
  - Within one port, write beats read; the pending read is serviced in a later transaction.
  - On grant, latch owner, op, `addr` and `wdata`, then go to WAIT.
- **WAIT**
  - Hold `mem_read_en` or `mem_write_en` (never both), `mem_addr` and `mem_wdata` constant.
  - On `mem_ready`:
    - Drop the downstream enable.
    - For a read, capture `mem_rdata` into the owner's `rdata` register.
    - Go to RESP.
- **RESP**
  - The owner's `ready` is high for exactly one cycle.
  - The pointer flips to the non-owner port.
  - Go to IDLE.
- Requests are ignored in WAIT and RESP.
- Busy outputs: `x_read_busy` = owner==x and op==read and state!=IDLE; same rule for write.
- `x_rdata` holds its last value until the next read completes for that port; writes leave it unchanged.
- Requester rule: deassert the enable on the edge that samples `ready` high. A still-high enable in IDLE is treated as a new request.
- Inputs `mem_ready` in IDLE or RESP are ignored.
- Reset values:
  - All outputs 0, including `rdata` registers.
  - State IDLE; pointer = port I.
- Reset mid-transaction: enables drop asynchronously, no `ready` is issued, and the owner must re-request.

## Timing
- Request high before edge E0 (state IDLE) → `mem_*_en` high in cycle E0–E1.
- `mem_ready` sampled at edge Ek → `x_ready` and `x_rdata` valid in cycle Ek–Ek+1.
- Minimum request-to-ready latency: 2 cycles (memory answering in its first cycle).
- Minimum spacing between grants: 3 cycles (WAIT, RESP, IDLE).
- Loser of a tie waits at most one full transaction plus one IDLE cycle.

## Configuration
- `OFFCHIP_ARB_TIMEOUT_EN` defined:
  - A 10-bit-minimum counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching `TIMEOUT_CYCLES` without `mem_ready`:
    - Drop the downstream enable.
    - Pulse `mem_timeout` and the owner's `ready` together; `rdata` is forced to 0 for reads.
    - Go to RESP handling, including the pointer flip.
  - `mem_ready` coinciding with the terminal count wins; no timeout is raised.
- Undefined: no counter; `mem_timeout` tied 0; WAIT lasts until `mem_ready`.

## Test plan
- I read at 0x100, memory returns 0xA5… after 3 cycles → `mem_read_en` high 3 cycles; `i_ready` 1 pulse; `i_rdata`=0xA5…; D outputs unchanged.
- I and D both request in the same cycle out of reset → I served first, then D. With both re-requesting continuously, the grant order is I, D, I, D.
- D asserts read and write together → write issued first with `d_write_busy`=1, then read. `d_rdata` changes only after the read.
- Async reset asserted mid-WAIT → `mem_*_en` low immediately, no `ready` pulse, state IDLE, pointer = I.
- Timeout build with `TIMEOUT_CYCLES`=8 and memory silent → after 8 WAIT cycles `mem_timeout`=1 and `i_ready`=1 with `i_rdata`=0. The next transaction completes normally.
- `mem_ready` pulsed while in IDLE → no `ready` output, no state change.
